// File: rtl/sram_mp_pkg.sv
// Shared types and helpers for the multi-port SRAM model.
package sram_mp_pkg;

   // Array content at time 0
   typedef enum logic [1:0] {
      INIT_ZEROS,
      INIT_ONES,
      INIT_RANDOM,
      INIT_NONE
   } init_e;

   // Widest strobe vector the collision helper accepts
   localparam int unsigned MAX_LANES = 128;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // Deterministic pseudo-random fill bit for bit position idx
   function automatic logic scramble_bit(input int unsigned idx);
      int unsigned h;
      h = (idx + 1) * 32'h9E37_79B1;
      return h[13];
   endfunction

   // Two writes collide when they hit the same word with at least one shared lane
   function automatic logic lanes_collide(
      input logic                 a_wr,
      input logic                 b_wr,
      input int unsigned          a_addr,
      input int unsigned          b_addr,
      input logic [MAX_LANES-1:0] a_be,
      input logic [MAX_LANES-1:0] b_be
   );
      return a_wr && b_wr && (a_addr == b_addr) && (|(a_be & b_be));
   endfunction

endpackage

// File: rtl/sram_mp_if.sv
// Request/response bundle for all ports of sram_mp.
interface sram_mp_if
   import sram_mp_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned NUM_WORDS  = 1024
);
   localparam int unsigned BE_WIDTH = ceil_div(DATA_WIDTH, BYTE_WIDTH);
   localparam int unsigned AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef logic [AW-1:0]         addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [BE_WIDTH-1:0]   strb_t;

   logic  [NUM_PORTS-1:0] req_i;
   logic  [NUM_PORTS-1:0] we_i;
   addr_t [NUM_PORTS-1:0] addr_i;
   data_t [NUM_PORTS-1:0] wdata_i;
   strb_t [NUM_PORTS-1:0] be_i;
   data_t [NUM_PORTS-1:0] rdata_o;
   logic  [NUM_PORTS-1:0] rvalid_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  rdata_o, rvalid_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output rdata_o, rvalid_o
   );

endinterface

// File: rtl/sram_mp_rd_pipe.sv
// Per-port read pipeline: LATENCY valid/data stages; the last data stage
// only loads on valid so it holds the last delivered word.
module sram_mp_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [LATENCY-1:0]                 valid_d, valid_q;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] data_d,  data_q;

   // Shift valid every cycle; each data stage advances only behind a valid bit
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      valid_d[0] = valid_i;
      data_d[0]  = valid_i ? data_i : data_q[0];
      for (int unsigned s = 1; s < LATENCY; s++) begin
         valid_d[s] = valid_q[s-1];
         data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
      end
   end

   // Pipeline registers, cleared by asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign rvalid_o = valid_q[LATENCY-1];
   assign rdata_o  = data_q[LATENCY-1];

endmodule

// File: rtl/sram_mp.sv
// Multi-port behavioural SRAM: byte-strobed writes, read-first sampling,
// configurable read latency, lowest-port-wins write collisions.
module sram_mp
   import sram_mp_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned LATENCY    = 1,
   parameter string       SIM_INIT   = "zeros"
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   sram_mp_if.slave bus
);

   localparam int unsigned BE_WIDTH = ceil_div(DATA_WIDTH, BYTE_WIDTH);
   localparam int unsigned AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef logic [AW-1:0]         addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [BE_WIDTH-1:0]   strb_t;

   localparam bit INIT_OK = (SIM_INIT == "zeros") || (SIM_INIT == "ones") ||
                            (SIM_INIT == "random") || (SIM_INIT == "none");

   localparam init_e INIT_MODE = (SIM_INIT == "ones")   ? INIT_ONES   :
                                 (SIM_INIT == "random") ? INIT_RANDOM :
                                 (SIM_INIT == "none")   ? INIT_NONE   : INIT_ZEROS;

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
      $fatal(1, "sram_mp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (LATENCY < 1) begin : g_bad_latency
      $fatal(1, "sram_mp: LATENCY must be >= 1");
   end
   if (NUM_PORTS < 1) begin : g_bad_ports
      $fatal(1, "sram_mp: NUM_PORTS must be >= 1");
   end
   if (NUM_WORDS < 2) begin : g_bad_depth
      $fatal(1, "sram_mp: NUM_WORDS must be >= 2");
   end
   if (!INIT_OK) begin : g_bad_init
      $fatal(1, "sram_mp: SIM_INIT must be zeros, ones, random or none");
   end

   function automatic data_t fill_word(input init_e mode);
      data_t w;
      w = '0;
      case (mode)
         INIT_ONES:   w = '1;
         INIT_RANDOM: for (int unsigned i = 0; i < DATA_WIDTH; i++) w[i] = scramble_bit(i);
         INIT_NONE:   w = 'x;
         default:     w = '0;
      endcase
      return w;
   endfunction

   localparam data_t INIT_WORD = fill_word(INIT_MODE);

   // Storage is never touched by reset; its time-0 content comes from SIM_INIT
   data_t mem_q [NUM_WORDS] = '{default: INIT_WORD};

   logic  [NUM_PORTS-1:0] req, we, wr_en, rd_en, in_range;
   addr_t [NUM_PORTS-1:0] addr;
   data_t [NUM_PORTS-1:0] wdata, rd_word, rdata;
   strb_t [NUM_PORTS-1:0] be;
   logic  [NUM_PORTS-1:0] rvalid;
   logic                  wr_collision;

   assign req   = bus.req_i;
   assign we    = bus.we_i;
   assign addr  = bus.addr_i;
   assign wdata = bus.wdata_i;
   assign be    = bus.be_i;

   // Decode per-port read/write enables and sample the array for reads
   always_comb begin
      wr_en    = '0;
      rd_en    = '0;
      in_range = '0;
      rd_word  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         in_range[p] = (32'(addr[p]) < NUM_WORDS);
         wr_en[p]    = req[p] & we[p] & in_range[p];
         rd_en[p]    = req[p] & ~we[p];
         rd_word[p]  = in_range[p] ? mem_q[addr[p]] : 'x;
      end
   end

   // Flag any pair of ports writing overlapping lanes of one word
   always_comb begin
      wr_collision = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         for (int unsigned q = p + 1; q < NUM_PORTS; q++) begin
            if (lanes_collide(wr_en[p], wr_en[q], 32'(addr[p]), 32'(addr[q]),
                              MAX_LANES'(be[p]), MAX_LANES'(be[q])))
               wr_collision = 1'b1;
         end
      end
   end

   // Lane-merge writes; ports visited high to low so the last NBA, from the
   // lowest port index, wins every shared lane
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         for (int unsigned b = 0; b < BE_WIDTH; b++) begin
            if (wr_en[NUM_PORTS-1-i] && be[NUM_PORTS-1-i][b])
               mem_q[addr[NUM_PORTS-1-i]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                  wdata[NUM_PORTS-1-i][b*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Report collisions, out-of-range accesses and unknown control inputs
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if ($isunknown(req) || $isunknown(we & req)) begin
            $error("sram_mp: unknown value on req_i/we_i");
         end else begin
            if (wr_collision)
               $warning("sram_mp: write collision, lowest port wins shared lanes");
            if (|(req & ~in_range))
               $error("sram_mp: out-of-range address 0x%0h", addr);
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_pipe
      sram_mp_rd_pipe #(
         .DATA_WIDTH (DATA_WIDTH),
         .LATENCY    (LATENCY)
      ) u_rd_pipe (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .valid_i  (rd_en[p]),
         .data_i   (rd_word[p]),
         .rvalid_o (rvalid[p]),
         .rdata_o  (rdata[p])
      );
   end

   assign bus.rvalid_o = rvalid;
   assign bus.rdata_o  = rdata;

endmodule

// File: tb/tb_sram_mp.sv
// Directed bench for sram_mp: a 3-port LATENCY=2 instance for lane/collision
// behaviour and a 2-port LATENCY=3 instance for streaming and mid-flight reset.
module tb_sram_mp;

   logic clk;
   logic rst_a_n, rst_b_n;
   int   checks = 0;
   int   errors = 0;

   sram_mp_if #(.NUM_PORTS(3), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_WORDS(64)) ia ();
   sram_mp_if #(.NUM_PORTS(2), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_WORDS(64)) ib ();

   sram_mp #(
      .NUM_PORTS(3), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_WORDS(64),
      .LATENCY(2), .SIM_INIT("zeros")
   ) dut_a (
      .clk_i  (clk),
      .rst_ni (rst_a_n),
      .bus    (ia)
   );

   sram_mp #(
      .NUM_PORTS(2), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_WORDS(64),
      .LATENCY(3), .SIM_INIT("zeros")
   ) dut_b (
      .clk_i  (clk),
      .rst_ni (rst_b_n),
      .bus    (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned port;
      bit          we;
      int unsigned addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      ia.req_i = '0; ia.we_i = '0; ia.addr_i = '0; ia.wdata_i = '0; ia.be_i = '0;
   endtask

   task automatic a_set(input int unsigned p, input bit w, input int unsigned a,
                        input logic [31:0] d, input logic [3:0] b);
      ia.req_i[p] = 1'b1; ia.we_i[p] = w; ia.addr_i[p] = a[5:0];
      ia.wdata_i[p] = d; ia.be_i[p] = b;
   endtask

   task automatic b_idle();
      ib.req_i = '0; ib.we_i = '0; ib.addr_i = '0; ib.wdata_i = '0; ib.be_i = '0;
   endtask

   task automatic b_set(input int unsigned p, input bit w, input int unsigned a,
                        input logic [31:0] d, input logic [3:0] b);
      ib.req_i[p] = 1'b1; ib.we_i[p] = w; ib.addr_i[p] = a[5:0];
      ib.wdata_i[p] = d; ib.be_i[p] = b;
   endtask

   function automatic logic [31:0] pat(input int unsigned i);
      return 32'h5000_0001 + i * 32'h0001_0101;
   endfunction

   initial begin
      //            port we addr wdata          be    expected read data
      tbl[0]  = '{0, 1, 3,  32'hAABB_CCDD, 4'hF, 32'h0};
      tbl[1]  = '{0, 1, 3,  32'h1122_3344, 4'h5, 32'h0};
      tbl[2]  = '{0, 0, 3,  32'h0,         4'h0, 32'hAA22_CC44};
      tbl[3]  = '{1, 1, 10, 32'h1234_5678, 4'hF, 32'h0};
      tbl[4]  = '{2, 0, 10, 32'h0,         4'h0, 32'h1234_5678};
      tbl[5]  = '{2, 1, 10, 32'hFFFF_FFFF, 4'h0, 32'h0};
      tbl[6]  = '{1, 0, 10, 32'h0,         4'h0, 32'h1234_5678};
      tbl[7]  = '{1, 1, 63, 32'hDEAD_BEEF, 4'h8, 32'h0};
      tbl[8]  = '{0, 0, 63, 32'h0,         4'h0, 32'hDE00_0000};
      tbl[9]  = '{0, 1, 0,  32'hCAFE_F00D, 4'h6, 32'h0};
      tbl[10] = '{1, 0, 0,  32'h0,         4'h0, 32'h00FE_F000};
      tbl[11] = '{2, 0, 20, 32'h0,         4'h0, 32'h0};

      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      a_idle();
      b_idle();
      repeat (3) @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      chk("reset_rvalid_a", 64'(ia.rvalid_o), 0);
      chk("reset_rdata_a0", ia.rdata_o[0], 0);
      chk("reset_rvalid_b", 64'(ib.rvalid_o), 0);
      chk("reset_rdata_b0", ib.rdata_o[0], 0);

      // LATENCY=2: request in cycle 0, rvalid only in cycle 2
      a_set(0, 0, 5, 32'h0, 4'h0);
      tick();
      a_idle();
      chk("lat_cycle1_rvalid", ia.rvalid_o[0], 0);
      tick();
      chk("lat_cycle2_rvalid", ia.rvalid_o[0], 1);
      chk("lat_cycle2_rdata", ia.rdata_o[0], 0);
      tick();
      chk("lat_cycle3_rvalid", ia.rvalid_o[0], 0);

      for (int i = 0; i < NV; i++) begin
         a_idle();
         a_set(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
         tick();
         a_idle();
         if (!tbl[i].we) begin
            tick();
            chk($sformatf("tbl%0d_rvalid", i), ia.rvalid_o[tbl[i].port], 1);
            chk($sformatf("tbl%0d_rdata", i), ia.rdata_o[tbl[i].port], 64'(tbl[i].exp));
         end
      end

      // Same-cycle read (P1) and write (P0) to addr 7 returns the old word
      a_set(0, 1, 7, 32'h1, 4'hF);
      tick();
      a_idle();
      a_set(0, 1, 7, 32'h2, 4'hF);
      a_set(1, 0, 7, 32'h0, 4'h0);
      tick();
      a_idle();
      a_set(1, 0, 7, 32'h0, 4'h0);
      tick();
      a_idle();
      chk("rw_same_rvalid", ia.rvalid_o[1], 1);
      chk("rw_same_old", ia.rdata_o[1], 32'h1);
      tick();
      chk("rw_next_rvalid", ia.rvalid_o[1], 1);
      chk("rw_next_new", ia.rdata_o[1], 32'h2);
      tick();
      chk("hold_rvalid", ia.rvalid_o[1], 0);
      chk("hold_rdata", ia.rdata_o[1], 32'h2);

      // Collision on addr 9: P0 owns lanes 0-1, P2 supplies lanes 2-3
      a_set(0, 1, 9, 32'h0000_00AA, 4'h3);
      a_set(2, 1, 9, 32'hDDCC_BBFF, 4'hF);
      tick();
      a_idle();
      a_set(0, 0, 9, 32'h0, 4'h0);
      tick();
      a_idle();
      tick();
      chk("collide_rvalid", ia.rvalid_o[0], 1);
      chk("collide_rdata", ia.rdata_o[0], 32'hDDCC_00AA);

      // Preload instance B: addrs 0..15 with a pattern, addr 20 with a marker
      for (int i = 0; i < 16; i++) begin
         b_idle();
         b_set(1, 1, i, pat(i), 4'hF);
         tick();
      end
      b_idle();
      b_set(1, 1, 20, 32'h5A5A_1234, 4'hF);
      tick();
      b_idle();
      tick();
      tick();
      tick();

      // LATENCY=3 streaming: reads in cycles 0..15, results in cycles 3..18
      for (int k = 0; k < 20; k++) begin
         b_idle();
         if (k < 16) b_set(0, 0, k, 32'h0, 4'h0);
         tick();
         if (k + 1 >= 3 && k + 1 <= 18) begin
            chk($sformatf("stream_c%0d_rvalid", k + 1), ib.rvalid_o[0], 1);
            chk($sformatf("stream_c%0d_rdata", k + 1), ib.rdata_o[0], 64'(pat(k - 2)));
         end else begin
            chk($sformatf("stream_c%0d_rvalid", k + 1), ib.rvalid_o[0], 0);
         end
      end
      b_idle();

      // Mid-flight reset: read in cycle 0, reset low through cycle 1
      b_set(0, 0, 20, 32'h0, 4'h0);
      tick();
      b_idle();
      chk("mid_pre_hold", ib.rdata_o[0], 64'(pat(15)));
      rst_b_n = 1'b0;
      #1;
      chk("mid_async_rdata", ib.rdata_o[0], 0);
      tick();
      rst_b_n = 1'b1;
      chk("mid_c2_rvalid", ib.rvalid_o[0], 0);
      tick();
      chk("mid_c3_rvalid", ib.rvalid_o[0], 0);
      chk("mid_c3_rdata", ib.rdata_o[0], 0);
      tick();
      chk("mid_c4_rvalid", ib.rvalid_o[0], 0);

      // Array survives reset
      b_set(0, 0, 20, 32'h0, 4'h0);
      tick();
      b_idle();
      tick();
      tick();
      chk("reread_rvalid", ib.rvalid_o[0], 1);
      chk("reread_rdata", ib.rdata_o[0], 32'h5A5A_1234);
      b_set(1, 0, 5, 32'h0, 4'h0);
      tick();
      b_idle();
      tick();
      tick();
      chk("reread5_rvalid", ib.rvalid_o[1], 1);
      chk("reread5_rdata", ib.rdata_o[1], 64'(pat(5)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
